pixel_fb_writer: RTL and testbench

PIXEL_FB_WRITER -- requirements
Module: pixel_fb_writer

---
 rtl/pixel_fb_writer.sv | 189 ++++++++++++++++++
 tb/tb_pixel_fb_writer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fb_writer.sv
`default_nettype none
// ============================================================================
// Module  : pixel_fb_writer
// Brief   : Captures synchronised pixel strobes and writes frames linearly
//           into a BRAM frame buffer under a one-hot capture state machine.
// Revision: 1.0 - initial release
// ============================================================================
module pixel_fb_writer #(
    parameter int H_WIDTH    = 320,
    parameter int V_WIDTH    = 240,
    parameter int PXL_WIDTH  = 16,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                       i_clk,
    input  logic                       i_n_reset,
    input  logic [PXL_WIDTH-1:0]       i_pixel_data,
    input  logic [$clog2(H_WIDTH):0]   i_h_addr,
    input  logic [$clog2(V_WIDTH):0]   i_v_addr,
    input  logic                       i_valid,
    input  logic                       i_start_capture,
    input  logic                       i_stop,
    input  logic                       i_continuous,
    output logic                       o_bram_we,
    output logic [ADDR_WIDTH-1:0]      o_bram_addr,
    output logic [PXL_WIDTH-1:0]       o_bram_din,
    output logic                       o_frame_done,
    output logic                       o_frame_err,
    output logic [7:0]                 o_frame_count,
    output logic [15:0]                o_drop_count,
    output logic [3:0]                 o_state,
    output logic                       o_busy
);
    localparam int HW = $clog2(H_WIDTH) + 1;
    localparam int VW = $clog2(V_WIDTH) + 1;
    localparam logic [HW-1:0]         C_H_MAX  = HW'(H_WIDTH);
    localparam logic [VW-1:0]         C_V_MAX  = VW'(V_WIDTH);
    localparam logic [VW-1:0]         C_V_LAST = VW'(V_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] C_STRIDE = ADDR_WIDTH'(H_WIDTH);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_ARM     = 4'b0010,
        ST_CAPTURE = 4'b0100,
        ST_DONE    = 4'b1000
    } state_t;

    logic                  sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d;
    logic                  evt_q, evt_d;
    logic [PXL_WIDTH-1:0]  pix_q, pix_d;
    logic [HW-1:0]         h_q, h_d;
    logic [VW-1:0]         v_q, v_d;
    state_t                ev_state_q, ev_state_d;
    state_t                state_q, state_d, px_next;
    logic                  px_move;
    logic                  we_q, we_d, done_q, done_d, err_q, err_d, busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PXL_WIDTH-1:0]  din_q, din_d;
    logic [7:0]            fcnt_q, fcnt_d;
    logic [15:0]           drop_q, drop_d;

    logic                  w_evt, w_oor, w_first, w_last;
    logic [HW-1:0]         w_col;
    logic [ADDR_WIDTH-1:0] w_addr;

    // Rising edge of the synchronised level marks one pixel, however long it stays high.
    assign w_evt   = sync2_q & ~dly_q;
    assign w_oor   = (h_q == '0) || (h_q > C_H_MAX) || (v_q >= C_V_MAX);
    assign w_first = (v_q == '0) && (h_q == HW'(1));
    assign w_last  = (v_q == C_V_LAST) && (h_q == C_H_MAX);
    assign w_col   = h_q - HW'(1);
    assign w_addr  = ADDR_WIDTH'(v_q) * C_STRIDE + ADDR_WIDTH'(w_col);

    always_comb begin
        sync1_d    = i_valid;
        sync2_d    = sync1_q;
        dly_d      = sync2_q;
        evt_d      = w_evt;
        pix_d      = w_evt ? i_pixel_data : pix_q;
        h_d        = w_evt ? i_h_addr     : h_q;
        v_d        = w_evt ? i_v_addr     : v_q;
        // The state seen at detection decides the write, so a stop arriving
        // while the pixel is in flight does not cancel it.
        ev_state_d = w_evt ? state_q : ev_state_q;

        we_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        fcnt_d  = fcnt_q;
        drop_d  = drop_q;
        px_next = state_q;
        px_move = 1'b0;

        if (evt_q) begin
            case (ev_state_q)
                ST_ARM: begin
                    if (w_first) begin
                        we_d    = 1'b1;
                        px_next = ST_CAPTURE;
                        px_move = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (w_oor) begin
                        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                    end else begin
                        we_d = 1'b1;
                        if (w_last) begin
                            done_d  = 1'b1;
                            fcnt_d  = fcnt_q + 8'd1;
                            px_next = i_continuous ? ST_ARM : ST_DONE;
                            px_move = 1'b1;
                        end else if (w_first) begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (we_d) begin
                addr_d = w_addr;
                din_d  = pix_q;
            end
        end

        state_d = state_q;
        if (i_stop)
            state_d = ST_IDLE;
        else if (px_move && (ev_state_q == state_q))
            state_d = px_next;
        else if (i_start_capture && ((state_q == ST_IDLE) || (state_q == ST_DONE)))
            state_d = ST_ARM;

        busy_d = (state_d == ST_ARM) || (state_d == ST_CAPTURE);
    end

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            dly_q      <= 1'b0;
            evt_q      <= 1'b0;
            pix_q      <= '0;
            h_q        <= '0;
            v_q        <= '0;
            ev_state_q <= ST_IDLE;
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            fcnt_q     <= '0;
            drop_q     <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            dly_q      <= dly_d;
            evt_q      <= evt_d;
            pix_q      <= pix_d;
            h_q        <= h_d;
            v_q        <= v_d;
            ev_state_q <= ev_state_d;
            state_q    <= state_d;
            we_q       <= we_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            fcnt_q     <= fcnt_d;
            drop_q     <= drop_d;
        end
    end

    assign o_bram_we     = we_q;
    assign o_bram_addr   = addr_q;
    assign o_bram_din    = din_q;
    assign o_frame_done  = done_q;
    assign o_frame_err   = err_q;
    assign o_frame_count = fcnt_q;
    assign o_drop_count  = drop_q;
    assign o_state       = state_q;
    assign o_busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_fb_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pixel_fb_writer
// Brief   : Directed self-checking bench for pixel_fb_writer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pixel_fb_writer;
    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] pixel = '0;
    logic [9:0]  h_addr = '0;
    logic [8:0]  v_addr = '0;
    logic        valid = 1'b0, start = 1'b0, stop = 1'b0, cont = 1'b0;
    logic        o_bram_we, o_frame_done, o_frame_err, o_busy;
    logic [16:0] o_bram_addr;
    logic [15:0] o_bram_din, o_drop_count;
    logic [7:0]  o_frame_count;
    logic [3:0]  o_state;

    int asserts = 0;
    int fails   = 0;

    int          n_we, lat, n_done, n_err, done_cyc;
    logic [16:0] a;
    logic [15:0] dout;

    localparam logic [3:0] S_IDLE = 4'b0001, S_ARM = 4'b0010, S_CAP = 4'b0100, S_DONE = 4'b1000;

    pixel_fb_writer dut (
        .i_clk(clk), .i_n_reset(n_reset), .i_pixel_data(pixel), .i_h_addr(h_addr),
        .i_v_addr(v_addr), .i_valid(valid), .i_start_capture(start), .i_stop(stop),
        .i_continuous(cont), .o_bram_we(o_bram_we), .o_bram_addr(o_bram_addr),
        .o_bram_din(o_bram_din), .o_frame_done(o_frame_done), .o_frame_err(o_frame_err),
        .o_frame_count(o_frame_count), .o_drop_count(o_drop_count), .o_state(o_state),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Drives one pixel with i_valid held for 'hold' cycles and records what the DUT did.
    task automatic run_pixel(input logic [8:0] v, input logic [9:0] h, input logic [15:0] d,
                             input int hold);
        n_we = 0; lat = 0; a = '0; dout = '0; n_done = 0; n_err = 0; done_cyc = 0;
        @(negedge clk);
        pixel = d; h_addr = h; v_addr = v; valid = 1'b1;
        for (int c = 1; c <= hold + 6; c++) begin
            @(posedge clk); #1;
            if (c == hold) valid = 1'b0;
            if (o_bram_we) begin
                n_we++;
                if (n_we == 1) begin lat = c; a = o_bram_addr; dout = o_bram_din; end
            end
            if (o_frame_done) begin n_done++; done_cyc = c; end
            if (o_frame_err) n_err++;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        asserts++; if (o_state !== S_IDLE) begin fails++; $display("FAIL reset_state: got %b expected %b", o_state, S_IDLE); end
        asserts++; if (o_bram_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b expected 0", o_bram_we); end
        asserts++; if (o_frame_count !== 8'd0) begin fails++; $display("FAIL reset_fcnt: got %0d expected 0", o_frame_count); end
        asserts++; if (o_drop_count !== 16'd0) begin fails++; $display("FAIL reset_drop: got %0d expected 0", o_drop_count); end
        asserts++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        n_reset = 1'b1;
    endtask

    task automatic test_idle_no_write();
        run_pixel(9'd0, 10'd1, 16'hABCD, 3);
        asserts++; if (n_we !== 0) begin fails++; $display("FAIL idle_write: got %0d writes expected 0", n_we); end
        asserts++; if (o_state !== S_IDLE) begin fails++; $display("FAIL idle_state: got %b expected %b", o_state, S_IDLE); end
    endtask

    task automatic test_arm_discard();
        pulse_start();
        asserts++; if (o_state !== S_ARM) begin fails++; $display("FAIL arm_state: got %b expected %b", o_state, S_ARM); end
        asserts++; if (o_busy !== 1'b1) begin fails++; $display("FAIL arm_busy: got %b expected 1", o_busy); end
        run_pixel(9'd5, 10'd10, 16'h1111, 3);
        asserts++; if (n_we !== 0) begin fails++; $display("FAIL arm_discard_write: got %0d writes expected 0", n_we); end
        asserts++; if (o_drop_count !== 16'd0) begin fails++; $display("FAIL arm_discard_drop: got %0d expected 0", o_drop_count); end
        asserts++; if (o_state !== S_ARM) begin fails++; $display("FAIL arm_discard_state: got %b expected %b", o_state, S_ARM); end
    endtask

    task automatic test_first_pixel();
        run_pixel(9'd0, 10'd1, 16'hF800, 10);
        asserts++; if (n_we !== 1) begin fails++; $display("FAIL first_nwe: got %0d expected 1", n_we); end
        asserts++; if (lat !== 4) begin fails++; $display("FAIL first_latency: got %0d expected 4", lat); end
        asserts++; if (a !== 17'd0) begin fails++; $display("FAIL first_addr: got %0d expected 0", a); end
        asserts++; if (dout !== 16'hF800) begin fails++; $display("FAIL first_din: got %h expected f800", dout); end
        asserts++; if (o_state !== S_CAP) begin fails++; $display("FAIL first_state: got %b expected %b", o_state, S_CAP); end
    endtask

    task automatic test_capture_writes();
        run_pixel(9'd1, 10'd1, 16'h07E0, 2);
        asserts++; if (n_we !== 1 || a !== 17'd320 || dout !== 16'h07E0) begin fails++; $display("FAIL cap_v1h1: got n=%0d addr=%0d din=%h expected n=1 addr=320 din=07e0", n_we, a, dout); end
        run_pixel(9'd2, 10'd7, 16'h001F, 1);
        asserts++; if (n_we !== 1 || a !== 17'd646 || dout !== 16'h001F) begin fails++; $display("FAIL cap_v2h7: got n=%0d addr=%0d din=%h expected n=1 addr=646 din=001f", n_we, a, dout); end
    endtask

    task automatic test_drops();
        run_pixel(9'd3, 10'd0, 16'h2222, 3);
        asserts++; if (n_we !== 0) begin fails++; $display("FAIL drop_h0_write: got %0d expected 0", n_we); end
        run_pixel(9'd240, 10'd5, 16'h3333, 3);
        asserts++; if (n_we !== 0) begin fails++; $display("FAIL drop_v240_write: got %0d expected 0", n_we); end
        asserts++; if (o_drop_count !== 16'd2) begin fails++; $display("FAIL drop_count2: got %0d expected 2", o_drop_count); end
        run_pixel(9'd0, 10'd321, 16'h4444, 3);
        asserts++; if (n_we !== 0 || o_drop_count !== 16'd3) begin fails++; $display("FAIL drop_h321: got n=%0d drop=%0d expected n=0 drop=3", n_we, o_drop_count); end
        asserts++; if (o_state !== S_CAP) begin fails++; $display("FAIL drop_state: got %b expected %b", o_state, S_CAP); end
    endtask

    task automatic test_frame_err();
        run_pixel(9'd100, 10'd50, 16'h5555, 3);
        asserts++; if (n_we !== 1 || a !== 17'd32049) begin fails++; $display("FAIL err_pre_addr: got n=%0d addr=%0d expected n=1 addr=32049", n_we, a); end
        run_pixel(9'd0, 10'd1, 16'h6666, 3);
        asserts++; if (n_we !== 1 || a !== 17'd0 || dout !== 16'h6666) begin fails++; $display("FAIL err_write: got n=%0d addr=%0d din=%h expected n=1 addr=0 din=6666", n_we, a, dout); end
        asserts++; if (n_err !== 1 || n_done !== 0) begin fails++; $display("FAIL err_pulse: got err=%0d done=%0d expected err=1 done=0", n_err, n_done); end
        asserts++; if (o_frame_count !== 8'd0 || o_state !== S_CAP) begin fails++; $display("FAIL err_after: got fcnt=%0d state=%b expected fcnt=0 state=%b", o_frame_count, o_state, S_CAP); end
    endtask

    task automatic test_last_pixel();
        cont = 1'b0;
        run_pixel(9'd239, 10'd320, 16'h7777, 3);
        asserts++; if (n_we !== 1 || a !== 17'd76799) begin fails++; $display("FAIL last_addr: got n=%0d addr=%0d expected n=1 addr=76799", n_we, a); end
        asserts++; if (n_done !== 1 || done_cyc !== lat) begin fails++; $display("FAIL last_done: got done=%0d at %0d expected 1 at %0d", n_done, done_cyc, lat); end
        asserts++; if (o_frame_count !== 8'd1) begin fails++; $display("FAIL last_fcnt: got %0d expected 1", o_frame_count); end
        asserts++; if (o_state !== S_DONE || o_busy !== 1'b0) begin fails++; $display("FAIL last_state: got state=%b busy=%b expected %b busy=0", o_state, o_busy, S_DONE); end
        run_pixel(9'd0, 10'd1, 16'h8888, 3);
        asserts++; if (n_we !== 0 || o_state !== S_DONE) begin fails++; $display("FAIL done_no_write: got n=%0d state=%b expected n=0 state=%b", n_we, o_state, S_DONE); end
    endtask

    task automatic test_continuous();
        pulse_start();
        run_pixel(9'd0, 10'd1, 16'h9999, 3);
        asserts++; if (o_state !== S_CAP) begin fails++; $display("FAIL cont_cap: got %b expected %b", o_state, S_CAP); end
        cont = 1'b1;
        run_pixel(9'd239, 10'd320, 16'hAAAA, 3);
        asserts++; if (n_done !== 1 || o_frame_count !== 8'd2) begin fails++; $display("FAIL cont_done: got done=%0d fcnt=%0d expected done=1 fcnt=2", n_done, o_frame_count); end
        asserts++; if (o_state !== S_ARM || o_busy !== 1'b1) begin fails++; $display("FAIL cont_rearm: got state=%b busy=%b expected %b busy=1", o_state, o_busy, S_ARM); end
        cont = 1'b0;
    endtask

    task automatic test_stop_start();
        run_pixel(9'd0, 10'd1, 16'hBBBB, 3);
        @(negedge clk); stop = 1'b1; start = 1'b1;
        @(posedge clk); #1; stop = 1'b0; start = 1'b0;
        asserts++; if (o_state !== S_IDLE || o_busy !== 1'b0) begin fails++; $display("FAIL stop_wins: got state=%b busy=%b expected %b busy=0", o_state, o_busy, S_IDLE); end
        repeat (3) @(posedge clk);
        #1;
        asserts++; if (o_state !== S_IDLE) begin fails++; $display("FAIL stop_stays: got %b expected %b", o_state, S_IDLE); end
    endtask

    task automatic test_stop_pipeline();
        pulse_start();
        run_pixel(9'd0, 10'd1, 16'hCCCC, 3);
        @(negedge clk); pixel = 16'h1234; h_addr = 10'd3; v_addr = 9'd3; valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        asserts++; if (o_state !== S_IDLE || o_bram_we !== 1'b0) begin fails++; $display("FAIL pipe_stop_state: got state=%b we=%b expected %b we=0", o_state, o_bram_we, S_IDLE); end
        @(posedge clk); #1;
        asserts++; if (o_bram_we !== 1'b1 || o_bram_addr !== 17'd962 || o_bram_din !== 16'h1234) begin fails++; $display("FAIL pipe_write: got we=%b addr=%0d din=%h expected we=1 addr=962 din=1234", o_bram_we, o_bram_addr, o_bram_din); end
        valid = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic test_reset_mid_write();
        pulse_start();
        @(negedge clk); pixel = 16'hDDDD; h_addr = 10'd1; v_addr = 9'd0; valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        asserts++; if (o_bram_we !== 1'b1) begin fails++; $display("FAIL rst_pre_we: got %b expected 1", o_bram_we); end
        n_reset = 1'b0; valid = 1'b0;
        #1;
        asserts++; if (o_bram_we !== 1'b0 || o_state !== S_IDLE) begin fails++; $display("FAIL rst_mid_we: got we=%b state=%b expected we=0 state=%b", o_bram_we, o_state, S_IDLE); end
        asserts++; if (o_frame_count !== 8'd0 || o_drop_count !== 16'd0) begin fails++; $display("FAIL rst_mid_counts: got fcnt=%0d drop=%0d expected 0 0", o_frame_count, o_drop_count); end
        repeat (2) @(posedge clk);
        @(negedge clk); n_reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        asserts++; if (o_state !== S_IDLE) begin fails++; $display("FAIL rst_release_state: got %b expected %b", o_state, S_IDLE); end
        run_pixel(9'd0, 10'd1, 16'hEEEE, 3);
        asserts++; if (n_we !== 0 || o_state !== S_IDLE) begin fails++; $display("FAIL rst_release_idle: got n=%0d state=%b expected n=0 state=%b", n_we, o_state, S_IDLE); end
    endtask

    initial begin
        test_reset();
        test_idle_no_write();
        test_arm_discard();
        test_first_pixel();
        test_capture_writes();
        test_drops();
        test_frame_err();
        test_last_pixel();
        test_continuous();
        test_stop_start();
        test_stop_pipeline();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
`default_nettype wire
